// File: rtl/fixed_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fixed_alu_arbiter
// Description : Round-robin arbiter that shares one Q6.26 fixed-point
//               datapath (ADD, SUB, MUL, CMP) between N_REQ requesters and
//               returns id-tagged results on one response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_alu_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [2*N_REQ-1:0]   req_op,
   input  logic [32*N_REQ-1:0]  req_a,
   input  logic [32*N_REQ-1:0]  req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [31:0]          rsp_data,
   output logic                 rsp_ovf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [1:0] c_OP_ADD = 2'b00;
   localparam logic [1:0] c_OP_SUB = 2'b01;
   localparam logic [1:0] c_OP_MUL = 2'b10;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [1:0]        op_q, op_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic [31:0]       rsp_data_q, rsp_data_d;
   logic              rsp_ovf_q, rsp_ovf_d;

   logic              w_any_valid;
   logic [ID_W-1:0]   w_grant_id;
   logic [N_REQ-1:0]  w_grant_vec;

   logic [31:0]       w_sum, w_diff, w_mag_a, w_mag_b, w_prod_mag, w_mul;
   logic [63:0]       w_prod;
   logic              w_ge;
   logic [31:0]       w_result;
   logic              w_ovf;
   logic              w_unused_prod;

   // Round-robin search: scan from ptr upward with wrap, first valid wins.
   always_comb begin
      w_any_valid = 1'b0;
      w_grant_id  = '0;
      w_grant_vec = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_any_valid && req_valid[(int'(ptr_q) + k) % N_REQ]) begin
            w_any_valid = 1'b1;
            w_grant_id  = ID_W'((int'(ptr_q) + k) % N_REQ);
            w_grant_vec[(int'(ptr_q) + k) % N_REQ] = 1'b1;
         end
      end
   end

   assign req_ready = (state_q == S_IDLE) ? w_grant_vec : '0;

   // Shared datapath on the registered operands; MUL is sign-magnitude with
   // the product truncated to bits [57:26] to stay in Q6.26.
   always_comb begin
      w_sum      = a_q + b_q;
      w_diff     = a_q - b_q;
      w_mag_a    = a_q[31] ? (~a_q + 32'd1) : a_q;
      w_mag_b    = b_q[31] ? (~b_q + 32'd1) : b_q;
      w_prod     = {32'd0, w_mag_a} * {32'd0, w_mag_b};
      w_prod_mag = w_prod[57:26];
      w_mul      = (a_q[31] ^ b_q[31]) ? (~w_prod_mag + 32'd1) : w_prod_mag;
      w_ge       = ($signed(a_q) >= $signed(b_q));
      w_result   = {31'd0, w_ge};
      w_ovf      = 1'b0;
      case (op_q)
         c_OP_ADD: begin
            w_result = w_sum;
            w_ovf    = (a_q[31] == b_q[31]) && (w_sum[31] != a_q[31]);
         end
         c_OP_SUB: begin
            w_result = w_diff;
            w_ovf    = (a_q[31] != b_q[31]) && (w_diff[31] != a_q[31]);
         end
         c_OP_MUL: begin
            w_result = w_mul;
         end
         default: begin
            w_result = {31'd0, w_ge};
         end
      endcase
   end

   // Discarded product bits (integer overflow and sub-LSB fraction).
   assign w_unused_prod = ^{w_prod[63:58], w_prod[25:0]};

   // Sequencer next-state: accept in IDLE, compute in EXEC, hold in RESP.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      rsp_data_d = rsp_data_q;
      rsp_ovf_d  = rsp_ovf_q;
      case (state_q)
         S_IDLE: begin
            if (w_any_valid) begin
               id_d    = w_grant_id;
               op_d    = req_op[2*w_grant_id +: 2];
               a_d     = req_a[32*w_grant_id +: 32];
               b_d     = req_b[32*w_grant_id +: 32];
               ptr_d   = (int'(w_grant_id) == N_REQ - 1) ? '0 : w_grant_id + ID_W'(1);
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            rsp_data_d = w_result;
            rsp_ovf_d  = w_ovf;
            state_d    = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and data registers; reset drops any in-flight operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         id_q       <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         rsp_data_q <= '0;
         rsp_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         rsp_data_q <= rsp_data_d;
         rsp_ovf_q  <= rsp_ovf_d;
      end
   end

   assign rsp_valid = (state_q == S_RESP);
   assign rsp_id    = id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_ovf   = rsp_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixed_alu_arbiter
// Description : Directed self-checking bench for fixed_alu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_alu_arbiter;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [N_REQ-1:0]     req_valid;
   logic [N_REQ-1:0]     req_ready;
   logic [2*N_REQ-1:0]   req_op;
   logic [32*N_REQ-1:0]  req_a;
   logic [32*N_REQ-1:0]  req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [31:0]          rsp_data;
   logic                 rsp_ovf;

   int checks = 0;
   int errors = 0;

   fixed_alu_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_ovf   (rsp_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[2*id +: 2] = op;
      req_a[32*id +: 32] = a;
      req_b[32*id +: 32] = b;
   endtask

   // Sync reset pulse, released at a falling edge.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   // Single-requester transaction with rsp_ready high; starts in IDLE.
   task automatic do_op(input string tag, input int id, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_data, input logic exp_ovf);
      @(negedge clk);
      set_req(id, op, a, b);
      req_valid = '0;
      req_valid[id] = 1'b1;
      #1;
      check({tag, "_grant"}, 32'(req_ready), 32'(1) << id);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      #1;
      check({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      #1;
      check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_id"}, 32'(rsp_id), 32'(id));
      check({tag, "_data"}, rsp_data, exp_data);
      check({tag, "_ovf"}, 32'(rsp_ovf), 32'(exp_ovf));
   endtask

   // Waits (bounded) for a grant in IDLE and checks it, then lets it be accepted.
   task automatic expect_grant(input string tag, input int exp_id);
      int cnt;
      cnt = 0;
      while (req_ready == '0 && cnt < 8) begin
         @(negedge clk);
         #1;
         cnt++;
      end
      check(tag, 32'(req_ready), 32'(1) << exp_id);
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] held_data;
      rst_n     = 1'b0;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      // Reset state
      do_reset();
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);

      // Arithmetic
      do_op("mul_pos", 0, 2'b10, 32'h06000000, 32'h08000000, 32'h0C000000, 1'b0);
      do_op("mul_neg", 0, 2'b10, 32'hFA000000, 32'h08000000, 32'hF4000000, 1'b0);
      do_op("add_ovf", 2, 2'b00, 32'h7C000000, 32'h08000000, 32'h84000000, 1'b1);
      do_op("add_ok",  2, 2'b00, 32'h04000000, 32'h04000000, 32'h08000000, 1'b0);
      do_op("sub_ovf", 3, 2'b01, 32'h80000000, 32'h04000000, 32'h7C000000, 1'b1);
      do_op("cmp_lt",  1, 2'b11, 32'hFC000000, 32'h04000000, 32'h00000000, 1'b0);
      do_op("cmp_gt",  1, 2'b11, 32'h04000000, 32'hFC000000, 32'h00000001, 1'b0);
      do_op("cmp_eq",  1, 2'b11, 32'h04000000, 32'h04000000, 32'h00000001, 1'b0);

      // Backpressure: req 1 ADD 1.0+2.0 held in RESP while req 2 waits
      @(negedge clk);
      rsp_ready = 1'b0;
      set_req(1, 2'b00, 32'h04000000, 32'h08000000);
      set_req(2, 2'b11, 32'h08000000, 32'h04000000);
      req_valid = 4'b0010;
      #1;
      check("bp_grant1", 32'(req_ready), 32'h2);
      @(posedge clk);
      @(negedge clk);
      req_valid = 4'b0100;
      @(negedge clk);
      #1;
      held_data = 32'h0C000000;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_id", 32'(rsp_id), 32'd1);
         check("bp_data", rsp_data, held_data);
         check("bp_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      check("bp_next_grant", 32'(req_ready), 32'h4);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
      check("bp_next_id", 32'(rsp_id), 32'd2);
      check("bp_next_data", rsp_data, 32'd1);

      // Round-robin, all four requesting from reset
      for (int i = 0; i < N_REQ; i++) set_req(i, 2'b00, 32'(i), 32'd0);
      do_reset();
      req_valid = 4'b1111;
      #1;
      expect_grant("rr_all_0", 0);
      expect_grant("rr_all_1", 1);
      expect_grant("rr_all_2", 2);
      expect_grant("rr_all_3", 3);
      expect_grant("rr_all_4", 0);
      expect_grant("rr_all_5", 1);
      req_valid = '0;

      // Round-robin, only 1 and 3 requesting from reset
      do_reset();
      req_valid = 4'b1010;
      #1;
      expect_grant("rr_odd_0", 1);
      expect_grant("rr_odd_1", 3);
      expect_grant("rr_odd_2", 1);
      expect_grant("rr_odd_3", 3);
      req_valid = '0;
      repeat (4) @(negedge clk);

      // Reset while in RESP: response lost, pointer back to 0
      rsp_ready = 1'b0;
      req_valid = 4'b0010;
      #1;
      check("rmid_grant", 32'(req_ready), 32'h2);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
      check("rmid_in_resp", 32'(rsp_valid), 32'd1);
      req_valid = 4'b1111;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rmid_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rmid_rsp_data", rsp_data, 32'd0);
      check("rmid_grant0", 32'(req_ready), 32'h1);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
      check("rmid_next_valid", 32'(rsp_valid), 32'd1);
      check("rmid_next_id", 32'(rsp_id), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fixed_alu_arbiter.md
# fixed_alu_arbiter

Round-robin arbiter and sequencer that shares one fixed-point arithmetic datapath between N_REQ requesters. The datapath is built from the team's addfixed, subfixed, multfixed and comparefixedpoint units. Each requester issues one operation over a valid/ready handshake. The block grants one requester at a time, registers its operands, and executes the selected operation. It returns the result on a single shared response channel tagged with the requester id. Data is 32-bit two's-complement Q6.26, matching the multfixed truncation of product bits [57:26].

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of rsp_id; must satisfy 2^ID_W >= N_REQ.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  N_REQ  request i is pending.
- req_ready  out  N_REQ  one-hot grant; request i is accepted on a cycle where req_valid[i] & req_ready[i].
- req_op  in  2*N_REQ  op for requester i in bits [2i+1:2i]: 00 ADD, 01 SUB, 10 MUL, 11 CMP.
- req_a  in  32*N_REQ  operand a for requester i in bits [32i+31:32i].
- req_b  in  32*N_REQ  operand b for requester i, packed the same way.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_data  out  32  result.
- rsp_ovf  out  1  signed overflow flag (ADD/SUB only).

## Operation
State machine:
- **IDLE**: req_ready is the one-hot round-robin grant among asserted req_valid bits. It is combinational from req_valid and ptr.
  - If any request is valid: capture op, a, b and id of the granted requester; set ptr = granted id + 1 (mod N_REQ); go to EXEC.
  - If no request is valid: stay in IDLE.
- **EXEC**: req_ready = 0.
  - Drive the registered operands through the selected unit.
  - Register rsp_data and rsp_ovf.
  - Go to RESP.
- **RESP**: rsp_valid = 1 and req_ready = 0.
  - rsp_id, rsp_data and rsp_ovf are held stable.
  - If rsp_ready: go to IDLE. Otherwise stay in RESP.

Round-robin rule: the search starts at ptr and wraps past N_REQ-1 to 0. The first asserted bit wins.

Arithmetic rules:
- ADD: rsp_data = a + b, mod 2^32. rsp_ovf = (a[31]==b[31]) & (q[31]!=a[31]).
- SUB: rsp_data = a - b. rsp_ovf = (a[31]!=b[31]) & (q[31]!=a[31]).
- MUL: rsp_data = the multfixed result (sign-magnitude product, bits [57:26]). Integer bits above bit 57 are discarded silently. rsp_ovf = 0.
- CMP: rsp_data = 32'h00000001 if a >= b (signed), else 32'h00000000. rsp_ovf = 0.

Requester rules:
- req_valid must not depend on req_ready.
- Once raised, req_valid, req_op, req_a and req_b are held until accepted.
- A requester that drops req_valid before acceptance is simply not granted.

## Timing
Reset values:
- State IDLE, ptr = 0.
- rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_ovf = 0.
- req_ready is driven by the IDLE grant logic; it is 0 if no request is valid.

Reset mid-operation (EXEC or RESP): the pending operation is discarded and no response is issued. Everything returns to the reset values on the next edge.

Latency and throughput:
- Acceptance at edge T; the result is registered at T+1; rsp_valid is high during the cycle after T+1.
- With rsp_ready held high, one op completes every 3 cycles: IDLE, EXEC, RESP.
- No new request is accepted while EXEC or RESP is occupied.
- A requester whose req_valid stays asserted after its response is re-granted only after every other valid requester has been served.

## Test plan
- **MUL**: req 0, MUL, a=0x06000000 (1.5), b=0x08000000 (2.0) → rsp_data=0x0C000000, rsp_id=0, rsp_ovf=0, rsp_valid 2 cycles after acceptance. Repeat with a=0xFA000000 (-1.5) → 0xF4000000.
- **ADD overflow**: req 2, ADD, a=0x7C000000, b=0x08000000 → rsp_data=0x84000000, rsp_ovf=1. SUB with a=0x80000000, b=0x04000000 → 0x7C000000, rsp_ovf=1.
- **Round-robin**: all four req_valid held from reset, rsp_ready=1 → grant order 0,1,2,3,0,1. With only 1 and 3 valid → 1,3,1,3.
- **Backpressure**: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_id and rsp_data constant, req_ready=0 throughout. The next grant occurs in the cycle after the rsp_ready handshake.
- **CMP**: a=0xFC000000 (-1.0), b=0x04000000 (1.0) → 0. Swapped operands → 1. Equal operands → 1.
- **Reset mid-op**: rst_n low for 1 cycle while in RESP → rsp_valid=0 on the next cycle and the response is lost. Then ptr=0, so with all requesters valid requester 0 is granted first.
